// File: rtl/load_store_unit.sv
// Load/store unit driving a word-wide synchronous data memory with one-cycle read latency.
// Sub-word stores use read-modify-write because the memory can only write whole words.
module load_store_unit #(
  parameter int XLEN       = 32,
  parameter int ADDRESSLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDRESSLEN-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_fault,
  output logic [ADDRESSLEN-1:0] mem_address,
  output logic [XLEN-1:0]       mem_data,
  output logic                  mem_iWrite,
  input  logic [XLEN-1:0]       mem_out
);

  typedef enum logic [1:0] {IDLE, RD, MERGE, WR} state_t;

  state_t      state;
  logic [1:0]  byte_off;
  logic [2:0]  funct3_q;
  logic [15:0] wdata_q;
  logic        write_q;

  logic            accept;
  logic            fault;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_result;
  logic [XLEN-1:0] merged;

  assign req_ready  = (state == IDLE) && !rst;
  assign mem_iWrite = (state == WR) && !rst;
  assign accept     = req_valid && req_ready;

  always_comb begin
    fault = 1'b0;
    case (req_funct3)
      3'b000:  fault = 1'b0;
      3'b001:  fault = req_addr[0];
      3'b010:  fault = |req_addr[1:0];
      3'b100:  fault = req_write;
      3'b101:  fault = req_write | req_addr[0];
      default: fault = 1'b1;
    endcase
  end

  // Lane selection is little-endian: byte_off picks the byte, byte_off[1] the halfword.
  always_comb begin
    ld_byte     = mem_out[{byte_off, 3'b000} +: 8];
    ld_half     = mem_out[{byte_off[1], 4'b0000} +: 16];
    load_result = mem_out;
    case (funct3_q)
      3'b000:  load_result = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_result = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_result = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_result = {{(XLEN-16){1'b0}}, ld_half};
      default: load_result = mem_out;
    endcase
  end

  always_comb begin
    merged = mem_out;
    if (funct3_q[0])
      merged[{byte_off[1], 4'b0000} +: 16] = wdata_q;
    else
      merged[{byte_off, 3'b000} +: 8] = wdata_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_fault  <= 1'b0;
      mem_data    <= '0;
      mem_address <= '0;
      byte_off    <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            byte_off <= req_addr[1:0];
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata[15:0];
            write_q  <= req_write;
            if (fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= {req_addr[ADDRESSLEN-1:2], 2'b00};
              // Full-word stores skip the read; everything else needs the old word first.
              if (req_write && req_funct3 == 3'b010) begin
                mem_data <= req_wdata;
                state    <= WR;
              end else begin
                state <= RD;
              end
            end
          end
        end
        RD: state <= MERGE;
        MERGE: begin
          if (write_q) begin
            mem_data <= merged;
            state    <= WR;
          end else begin
            resp_valid <= 1'b1;
            resp_rdata <= load_result;
            state      <= IDLE;
          end
        end
        WR: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data, mem_out;
  logic        mem_iWrite;

  logic [31:0] mem [0:63];
  logic [7:0]  ref_mem [0:63];
  int          write_count = 0;
  int          tests = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .ADDRESSLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_data(mem_data), .mem_iWrite(mem_iWrite),
    .mem_out(mem_out)
  );

  // Word-wide synchronous memory: a write edge does not refresh the read port.
  always @(posedge clk) begin
    if (mem_iWrite) begin
      mem[mem_address[7:2]] <= mem_data;
      write_count <= write_count + 1;
    end else begin
      mem_out <= mem[mem_address[7:2]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic model_fault(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int size;
    bit illegal;
    size    = 1 << f3[1:0];
    illegal = (f3[1:0] == 2'b11) || (f3[2] && (wr || f3[1]));
    return illegal || ((a % size) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int size;
    longint v;
    size = 1 << f3[1:0];
    v    = 0;
    for (int i = 0; i < size; i++) v += longint'(ref_mem[int'(a) + i]) << (8 * i);
    if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int size;
    size = 1 << f3[1:0];
    for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input string tag, output logic [31:0] rdata);
    logic        exp_fault;
    logic [31:0] exp_rdata;
    int          exp_lat, lat, writes0;
    logic        busy_ready;
    exp_fault = model_fault(wr, f3, a);
    exp_rdata = (exp_fault || wr) ? 32'h0 : model_load(f3, a);
    exp_lat   = exp_fault ? 1 : (!wr ? 3 : (f3 == 3'b010 ? 2 : 4));
    writes0   = write_count;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    busy_ready = 1'b0;
    while (!resp_valid && lat < 10) begin
      busy_ready |= req_ready;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_fault"}, 32'(resp_fault), 32'(exp_fault));
    checkOutput({tag, "_rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "_ready_busy"}, 32'(busy_ready), 32'd0);
    rdata = resp_rdata;
    @(posedge clk); #1;
    checkOutput({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_writes"}, 32'(write_count - writes0), (wr && !exp_fault) ? 32'd1 : 32'd0);
    if (wr && !exp_fault) model_store(f3, a, wd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  t_f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] t_addr [6] = '{32'hA, 32'hA, 32'hA, 32'hA, 32'h9, 32'h8};
    logic [31:0] t_exp  [6] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF,
                                32'h0000007F, 32'h80FF7F01};
    int writes0, busy, lat;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset_resp_fault", 32'(resp_fault), 32'd0);
    checkOutput("reset_mem_address", mem_address, 32'd0);
    checkOutput("reset_mem_data", mem_data, 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_mem_iwrite", 32'(mem_iWrite), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b1, 3'b010, 32'h8, 32'h80FF7F01, "sw_preload", rd);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, t_f3[i], t_addr[i], 32'h0, "plan_load", rd);
      checkOutput("plan_load_value", rd, t_exp[i]);
    end

    applyStimulus(1'b1, 3'b000, 32'h9, 32'h123456AA, "sb_9", rd);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, "lw_after_sb", rd);
    checkOutput("lw_after_sb_value", rd, 32'h80FFAA01);
    applyStimulus(1'b1, 3'b001, 32'hA, 32'h0000BEEF, "sh_a", rd);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, "lw_after_sh", rd);
    checkOutput("lw_after_sh_value", rd, 32'hBEEFAA01);

    applyStimulus(1'b0, 3'b010, 32'h6, 32'h0, "fault_lw_6", rd);
    applyStimulus(1'b1, 3'b001, 32'h5, 32'hFFFFFFFF, "fault_sh_5", rd);
    applyStimulus(1'b0, 3'b011, 32'h8, 32'h0, "fault_f3_011", rd);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, "lw_after_faults", rd);
    checkOutput("lw_after_faults_value", rd, 32'hBEEFAA01);

    // Reset lands in the WR cycle of a byte store: nothing may reach memory.
    writes0 = write_count;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h9; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_reached", 32'(mem_iWrite), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_wr_gated", 32'(mem_iWrite), 32'd0);
    @(posedge clk); #1;
    checkOutput("rst_no_resp", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_ready_after", 32'(req_ready), 32'd1);
    checkOutput("rst_no_resp_after", 32'(resp_valid), 32'd0);
    checkOutput("rst_no_write", 32'(write_count - writes0), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, "lw_after_rst", rd);
    checkOutput("lw_after_rst_value", rd, 32'hBEEFAA01);

    // Streaming SW/LW pairs with req_valid held high.
    writes0 = write_count;
    req_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      req_write  = (k % 2 == 0);
      req_funct3 = 3'b010;
      req_addr   = 32'((k / 2) * 4);
      req_wdata  = $urandom;
      busy = 0;
      while (!req_ready && busy < 10) begin
        @(posedge clk); #1;
        busy++;
      end
      if (k > 0) begin
        checkOutput("b2b_busy", 32'(busy), (k % 2 == 1) ? 32'd1 : 32'd2);
        checkOutput("b2b_overlap", 32'(resp_valid), 32'd1);
        if (k % 2 == 0) checkOutput("b2b_lw_data", resp_rdata, model_load(3'b010, 32'(((k - 1) / 2) * 4)));
      end
      if (req_write) model_store(3'b010, req_addr, req_wdata);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("b2b_last_latency", 32'(lat), 32'd3);
    checkOutput("b2b_last_data", resp_rdata, model_load(3'b010, 32'h3C));
    checkOutput("b2b_writes", 32'(write_count - writes0), 32'd16);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 3'b010, 32'(i * 4), 32'h0, "readback", rd);
    end

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom, "random", rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
